// File: rtl/mmu_demux_pkg.sv
// Shared types and constants for the five-way MMU response demultiplexer.
package mmu_demux_pkg;

  localparam int unsigned NUM_PORTS_C = 5;
  localparam int unsigned SEL_WIDTH_C = 3;

  typedef enum logic {IDLE, DISPATCH} top_state_t;
  typedef enum logic {EMPTY, WAIT} slot_state_t;

endpackage

// File: rtl/mmu_demux_slot.sv
// One downstream port slot: parks a dispatched payload, pulses o_drive, and
// holds the data until the consumer returns free.
module mmu_demux_slot
  import mmu_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_free,
  output logic                  o_drive,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_spur
);

  slot_state_t           r_state;
  slot_state_t           w_state_d;
  logic                  r_drive;
  logic [DATA_WIDTH-1:0] r_data;

  // A free and a load in the same cycle: free first, then reload, so the
  // slot ends up WAIT holding the new payload.
  always_comb begin
    w_state_d = r_state;
    if (i_free && (r_state == WAIT)) begin
      w_state_d = EMPTY;
    end
    if (i_load) begin
      w_state_d = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_drive <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_drive <= i_load;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_drive = r_drive;
  assign o_data  = r_data;
  assign o_busy  = (r_state == WAIT);
  assign o_spur  = i_free && (r_state == EMPTY);

endmodule

// File: rtl/mmu_resp_demux5.sv
// One-to-five demultiplexer for the MMU drive/free handshake: captures a
// request, routes it to the selected port slot and releases upstream.
module mmu_resp_demux5
  import mmu_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned SEL_WIDTH  = SEL_WIDTH_C,
  parameter int unsigned STALL_MAX  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_drive,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SEL_WIDTH-1:0]   i_sel,
  output logic                   o_free,
  output logic                   o_drive0,
  output logic                   o_drive1,
  output logic                   o_drive2,
  output logic                   o_drive3,
  output logic                   o_drive4,
  output logic [DATA_WIDTH-1:0]  o_data0,
  output logic [DATA_WIDTH-1:0]  o_data1,
  output logic [DATA_WIDTH-1:0]  o_data2,
  output logic [DATA_WIDTH-1:0]  o_data3,
  output logic [DATA_WIDTH-1:0]  o_data4,
  input  logic                   i_free0,
  input  logic                   i_free1,
  input  logic                   i_free2,
  input  logic                   i_free3,
  input  logic                   i_free4,
  output logic [NUM_PORTS_C-1:0] o_busy,
  output logic                   o_err,
  output logic                   o_stall
);

  localparam int unsigned NUM_PORTS = NUM_PORTS_C;
  localparam logic [7:0]  STALL_MAX_W = 8'(STALL_MAX);

  top_state_t                            r_state;
  top_state_t                            w_state_d;
  logic [DATA_WIDTH-1:0]                 r_data;
  logic [SEL_WIDTH-1:0]                  r_sel;
  logic [NUM_PORTS-1:0]                  r_tgt;
  logic [7:0]                            r_cnt;
  logic                                  r_free;
  logic                                  r_err;
  logic                                  r_stall;

  logic [NUM_PORTS-1:0]                  w_free;
  logic [NUM_PORTS-1:0]                  w_busy;
  logic [NUM_PORTS-1:0]                  w_spur;
  logic [NUM_PORTS-1:0]                  w_drive;
  logic [NUM_PORTS-1:0]                  w_load;
  logic [NUM_PORTS-1:0]                  w_sel_oh;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  w_data;
  logic                                  w_go;
  logic                                  w_accept;
  logic                                  w_bad_sel;
  logic                                  w_drop;

  assign w_free   = {i_free4, i_free3, i_free2, i_free1, i_free0};
  assign w_sel_oh = NUM_PORTS'(1) << r_sel;

  // r_tgt is the registered one-hot decode of r_sel, filled in on the first
  // DISPATCH cycle; zero means not yet decoded, so no dispatch can fire.
  assign w_go = (r_state == DISPATCH) && ((r_tgt & (~w_busy | w_free)) != '0);

  always_comb begin
    w_state_d = r_state;
    w_load    = '0;
    w_accept  = 1'b0;
    w_bad_sel = 1'b0;
    w_drop    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_drive) begin
          if (i_sel >= SEL_WIDTH'(NUM_PORTS)) begin
            w_bad_sel = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_state_d = DISPATCH;
          end
        end
      end
      DISPATCH: begin
        w_drop = i_drive;
        if (w_go) begin
          w_load    = r_tgt;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_free  <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_data <= i_data;
        r_sel  <= i_sel;
      end
      if (w_go || (r_state != DISPATCH)) begin
        r_tgt <= '0;
      end else begin
        r_tgt <= w_sel_oh;
      end
      r_free <= w_go || w_bad_sel;
      r_err  <= w_bad_sel || w_drop || (|w_spur);
      // Watchdog: one pulse when the wait reaches STALL_MAX, then saturate.
      if ((r_state == DISPATCH) && !w_go) begin
        if (r_cnt != STALL_MAX_W) begin
          r_cnt <= r_cnt + 8'd1;
        end
        r_stall <= (r_cnt == (STALL_MAX_W - 8'd1));
      end else begin
        r_cnt   <= '0;
        r_stall <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
    mmu_demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[k]),
      .i_data (r_data),
      .i_free (w_free[k]),
      .o_drive(w_drive[k]),
      .o_data (w_data[k]),
      .o_busy (w_busy[k]),
      .o_spur (w_spur[k])
    );
  end

  assign o_free   = r_free;
  assign o_err    = r_err;
  assign o_stall  = r_stall;
  assign o_busy   = w_busy;
  assign o_drive0 = w_drive[0];
  assign o_drive1 = w_drive[1];
  assign o_drive2 = w_drive[2];
  assign o_drive3 = w_drive[3];
  assign o_drive4 = w_drive[4];
  assign o_data0  = w_data[0];
  assign o_data1  = w_data[1];
  assign o_data2  = w_data[2];
  assign o_data3  = w_data[3];
  assign o_data4  = w_data[4];

endmodule

// File: tb/tb_mmu_resp_demux5.sv
// Randomized bench for mmu_resp_demux5 against an event-level reference model.
module tb_mmu_resp_demux5;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_drive;
  logic [DW-1:0] i_data;
  logic [2:0]    i_sel;
  logic [4:0]    free_v;
  logic          o_free, o_err, o_stall;
  logic          d0, d1, d2, d3, d4;
  logic [DW-1:0] q0, q1, q2, q3, q4;
  logic [4:0]    o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_seen = 0;

  // Reference model state.
  bit            m_occ [5];
  logic [DW-1:0] m_data [5];
  bit            m_pend;
  int            m_sel;
  logic [DW-1:0] m_pdata;
  int            m_age;
  bit            e_free, e_err, e_stall;
  bit   [4:0]    e_drv;

  always #5 clk = ~clk;

  mmu_resp_demux5 u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_drive (i_drive),
    .i_data  (i_data),
    .i_sel   (i_sel),
    .o_free  (o_free),
    .o_drive0(d0),
    .o_drive1(d1),
    .o_drive2(d2),
    .o_drive3(d3),
    .o_drive4(d4),
    .o_data0 (q0),
    .o_data1 (q1),
    .o_data2 (q2),
    .o_data3 (q3),
    .o_data4 (q4),
    .i_free0 (free_v[0]),
    .i_free1 (free_v[1]),
    .i_free2 (free_v[2]),
    .i_free3 (free_v[3]),
    .i_free4 (free_v[4]),
    .o_busy  (o_busy),
    .o_err   (o_err),
    .o_stall (o_stall)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_occ[k]  = 1'b0;
      m_data[k] = '0;
    end
    m_pend = 1'b0; m_sel = 0; m_pdata = '0; m_age = 0;
    e_free = 1'b0; e_err = 1'b0; e_stall = 1'b0; e_drv = '0;
  endtask

  // What the outputs must show after one clock edge with these inputs.
  task automatic model_edge(input bit drv, input logic [2:0] sel, input logic [DW-1:0] data,
                            input bit [4:0] fr);
    bit was_pend;
    was_pend = m_pend;
    e_free = 1'b0; e_err = 1'b0; e_stall = 1'b0; e_drv = '0;
    for (int k = 0; k < 5; k++) begin
      if (fr[k]) begin
        if (m_occ[k]) m_occ[k] = 1'b0;
        else e_err = 1'b1;
      end
    end
    if (m_pend) begin
      // Target decode takes the first waiting cycle.
      if (m_age >= 1 && !m_occ[m_sel]) begin
        m_occ[m_sel]  = 1'b1;
        m_data[m_sel] = m_pdata;
        e_drv[m_sel]  = 1'b1;
        e_free        = 1'b1;
        m_pend        = 1'b0;
      end else if (m_age < 255) begin
        m_age++;
        if (m_age == 255) e_stall = 1'b1;
      end
    end
    if (drv) begin
      if (was_pend) begin
        e_err = 1'b1;
      end else if (sel >= 3'd5) begin
        e_err  = 1'b1;
        e_free = 1'b1;
      end else begin
        m_pend  = 1'b1;
        m_sel   = int'(sel);
        m_pdata = data;
        m_age   = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [4:0] busy_exp;
    for (int k = 0; k < 5; k++) busy_exp[k] = m_occ[k];
    check_eq("ctrl", DW'({o_free, o_err, o_stall, d4, d3, d2, d1, d0, o_busy}),
             DW'({e_free, e_err, e_stall, e_drv, busy_exp}));
    check_eq("data0", q0, m_data[0]);
    check_eq("data1", q1, m_data[1]);
    check_eq("data2", q2, m_data[2]);
    check_eq("data3", q3, m_data[3]);
    check_eq("data4", q4, m_data[4]);
  endtask

  task automatic cycle(input bit drv, input logic [2:0] sel, input logic [DW-1:0] data,
                       input bit [4:0] fr);
    i_drive = drv; i_sel = sel; i_data = data; free_v = fr;
    @(posedge clk);
    if (!rst) model_edge(drv, sel, data, fr);
    #1;
    compare_all();
    if (o_stall) stall_seen++;
    i_drive = 1'b0; free_v = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, '0, 5'd0);
  endtask

  task automatic do_reset();
    i_drive = 1'b0; free_v = '0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v_old, v_new;
    rst = 1'b0; i_drive = 1'b0; i_sel = '0; i_data = '0; free_v = '0;
    model_reset();
    #2;
    do_reset();

    // Basic route to port 2 with two-cycle latency.
    cycle(1'b1, 3'd2, DW'(8'hA5), 5'd0);
    cycle(1'b0, 3'd0, '0, 5'd0);
    check_eq("lat_not_early", DW'({o_free, d2}), DW'(2'b00));
    cycle(1'b0, 3'd0, '0, 5'd0);
    check_eq("lat_drive2", DW'({o_free, d2}), DW'(2'b11));
    check_eq("data2_a5", q2, DW'(8'hA5));
    check_eq("busy_00100", DW'(o_busy), DW'(5'b00100));
    cycle(1'b0, 3'd0, '0, 5'b00100);
    check_eq("busy_clear", DW'(o_busy), DW'(0));

    // Second request to an occupied port waits for the free.
    v_old = rand_data(); v_new = rand_data();
    cycle(1'b1, 3'd1, v_old, 5'd0);
    idle(3);
    cycle(1'b1, 3'd1, v_new, 5'd0);
    idle(5);
    check_eq("wait_data_old", q1, v_old);
    cycle(1'b0, 3'd0, '0, 5'b00010);
    check_eq("refill_drive1", DW'({o_free, d1}), DW'(2'b11));
    check_eq("refill_data1", q1, v_new);
    cycle(1'b0, 3'd0, '0, 5'b00010);
    idle(1);

    // Out-of-range select.
    cycle(1'b1, 3'd6, rand_data(), 5'd0);
    check_eq("bad_sel", DW'({o_err, o_free, d4, d3, d2, d1, d0}), DW'(7'b1100000));
    idle(2);

    // Stall watchdog on port 3.
    cycle(1'b1, 3'd3, rand_data(), 5'd0);
    idle(3);
    cycle(1'b1, 3'd3, rand_data(), 5'd0);
    stall_seen = 0;
    idle(300);
    check_eq("stall_count", DW'(stall_seen), DW'(1));
    cycle(1'b0, 3'd0, '0, 5'b01000);
    check_eq("stall_release", DW'(d3), DW'(1));
    cycle(1'b0, 3'd0, '0, 5'b01000);
    idle(2);

    // Spurious free, then free coinciding with a pending dispatch.
    cycle(1'b0, 3'd0, '0, 5'b00001);
    check_eq("spur_err", DW'({o_err, o_busy}), DW'(6'b100000));
    cycle(1'b1, 3'd0, rand_data(), 5'd0);
    idle(3);
    cycle(1'b1, 3'd0, rand_data(), 5'd0);
    idle(1);
    cycle(1'b0, 3'd0, '0, 5'b00001);
    check_eq("same_cycle_free", DW'({d0, o_busy[0]}), DW'(2'b11));
    cycle(1'b0, 3'd0, '0, 5'b00001);
    idle(1);

    // Reset in the middle of a dispatch with three slots occupied.
    cycle(1'b1, 3'd0, rand_data(), 5'd0); idle(3);
    cycle(1'b1, 3'd1, rand_data(), 5'd0); idle(3);
    cycle(1'b1, 3'd2, rand_data(), 5'd0); idle(3);
    cycle(1'b1, 3'd0, rand_data(), 5'd0); idle(1);
    do_reset();
    check_eq("rst_outputs", DW'({o_free, o_err, o_stall, o_busy}), DW'(0));
    v_new = rand_data();
    cycle(1'b1, 3'd4, v_new, 5'd0);
    idle(2);
    check_eq("post_rst_data4", q4, v_new);
    cycle(1'b0, 3'd0, '0, 5'b10000);

    // Random traffic.
    for (int n = 0; n < 1200; n++) begin
      logic [2:0] s;
      bit   [4:0] f;
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(9) < 8) ? 3'($urandom_range(4)) : 3'($urandom_range(7));
        for (int k = 0; k < 5; k++) f[k] = ($urandom_range(4) == 0);
        cycle($urandom_range(3) == 0, s, rand_data(), f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_resp_demux5.md
Name: mmu_resp_demux5

Overview:
- Synchronous one-to-five demultiplexer for the MMU drive/free handshake; the splitting counterpart of the five-way mutex merge.
- Accepts one upstream request (drive pulse, data, destination select) and routes it to exactly one of five downstream ports.
- Each port holds its data until that port returns free; upstream is released as soon as the data is parked in the port slot.
- Sits between the shared MMU response channel and the per-requester return paths.

Parameters:
- NUM_PORTS, 5, number of downstream ports (fixed at 5 by the port list).
- DATA_WIDTH, 128, payload width.
- SEL_WIDTH, 3, destination select width.
- STALL_MAX, 255, dispatch-wait cycles before o_stall pulses (8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_drive  in  1  one-cycle request pulse.
- i_data  in  DATA_WIDTH  payload; valid in the i_drive cycle.
- i_sel  in  SEL_WIDTH  destination port; valid in the i_drive cycle.
- o_free  out  1  one-cycle pulse releasing upstream.
- o_drive0..o_drive4  out  1  one-cycle pulse per port.
- o_data0..o_data4  out  DATA_WIDTH  port payload.
- i_free0..i_free4  in  1  one-cycle pulse from each downstream consumer.
- o_busy  out  NUM_PORTS  bit k = port k occupied.
- o_err  out  1  one-cycle protocol-error pulse.
- o_stall  out  1  one-cycle watchdog pulse.

Behaviour:
- All outputs are registered. On reset, every output is 0, all data registers are 0, all slots are EMPTY, the top FSM is IDLE and the stall counter is 0. Reset asserted mid-operation discards everything in flight and issues no frees.
- Top FSM has two states, IDLE and DISPATCH.
  - IDLE: when i_drive=1, capture i_data and i_sel.
    - If i_sel >= NUM_PORTS: o_err and o_free both pulse in the next cycle; the request is discarded; stay IDLE.
    - Otherwise go to DISPATCH.
  - DISPATCH: if slot[sel] is EMPTY, load it, pulse o_drive_sel and o_free in the same next cycle, and go to IDLE. If the slot is WAIT, stay and hold o_free low.
- Latency with the target slot empty: i_drive sampled at edge E0, then o_drive_k and o_free are high for the cycle after edge E2 (2 cycles). If the slot is occupied, dispatch occurs the cycle after the i_free_k edge.
- Slot k has two states, EMPTY and WAIT.
  - EMPTY -> WAIT on dispatch.
  - WAIT -> EMPTY on i_free_k.
  - o_data_k is stable from o_drive_k until i_free_k. After i_free_k it holds its last value; it is not cleared.
  - o_busy[k] = (slot k == WAIT).
- Simultaneous i_free_k and a pending dispatch to k in the same cycle: the free is applied first, and the dispatch proceeds in that same cycle. The slot stays WAIT and a fresh o_drive_k pulses next cycle.
- Frees on different ports in the same cycle are independent. Dispatch to port j is unaffected by WAIT on port k≠j.
- i_drive while the top FSM is DISPATCH: the new request is dropped, o_err pulses next cycle, and the held request is unaffected.
- i_free_k while slot k is EMPTY: ignored; o_err pulses next cycle.
- Multiple error causes in one cycle produce a single o_err pulse.
- Stall counter:
  - Counts cycles spent in DISPATCH and resets on leaving DISPATCH.
  - When the count reaches STALL_MAX, o_stall pulses once and the count saturates (no repeat pulse).
  - The request keeps waiting; no data is dropped.
- o_free and o_drive are never asserted on consecutive cycles for the same request. Exactly one o_free is issued per accepted i_drive.

Decomposition:
- Package mmu_demux_pkg holds:
  - localparams NUM_PORTS_C=5 and SEL_WIDTH_C=3;
  - enum top_state_t {IDLE, DISPATCH};
  - enum slot_state_t {EMPTY, WAIT}.
- Sub-module mmu_demux_slot: one per port. It contains the data register, the slot FSM, the o_drive pulse register and the spurious-free error flag. It is instantiated five times in a generate loop.
- The top level contains the capture registers, the top FSM, the stall counter and the o_free/o_err generation.

Test Plan:
- Reset, then i_drive with i_sel=2 and i_data=0xA5 (zero-extended) -> o_drive2 and o_free pulse 2 cycles later; o_data2=0xA5; o_busy=5'b00100. Then i_free2 -> o_busy=0.
- Port 1 occupied, then a second request to port 1 -> no o_free while waiting. Then i_free1 -> o_drive1 and o_free pulse the next cycle with the new data, and the old data is replaced only at that point.
- i_sel=6 -> o_err and o_free pulse 1 cycle later, no o_drive pulses, o_busy unchanged.
- Port 3 held with no free for 255 cycles -> exactly one o_stall pulse. Then i_free3 -> dispatch completes, counter cleared.
- i_free0 with slot 0 EMPTY -> o_err pulse, no state change. Then a pending request to 0 with i_free0 in the same cycle -> the new o_drive0 follows next cycle.
- rst asserted while in DISPATCH with 3 slots WAIT -> all outputs 0 immediately, no o_free. After release, a fresh request completes normally.
